// File: rtl/irq_collector.sv
// ---------------------------------------------------------------------------
// irq_collector
//
// Collects rising-edge interrupt events from 8 level request lines into a
// pending vector. Presents the highest-priority unmasked pending source
// (bit 7 highest) as a registered valid/id pair. The consumer accepts it with
// a ready handshake. An event on a source that is already pending merges into
// the existing pending bit and sets a sticky overrun flag.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        asynchronous active-high reset
//   i_en         presentation enable (0 blocks new ids from being presented)
//   i_req[7:0]   level request lines, a 0->1 transition is one event
//   i_mask[7:0]  per-source presentation mask (pending bits are kept)
//   i_irq_ready  consumer accepts the presented id
//   i_ovf_clr    synchronous clear of the overrun flag
//   o_irq_valid  an id is presented
//   o_irq_id     index of the presented source
//   o_pend[7:0]  pending vector
//   o_ovf        sticky overrun flag
// ---------------------------------------------------------------------------
module irq_collector (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_req,
    input  logic [7:0] i_mask,
    input  logic       i_irq_ready,
    input  logic       i_ovf_clr,
    output logic       o_irq_valid,
    output logic [2:0] o_irq_id,
    output logic [7:0] o_pend,
    output logic       o_ovf
);

    logic [7:0] r_req_q;
    logic [7:0] r_pend;
    logic       r_irq_valid;
    logic [2:0] r_irq_id;
    logic       r_ovf;

    logic [7:0] w_edge;
    logic       w_acc;
    logic [7:0] w_clr;
    logic [7:0] w_pend_next;
    logic [7:0] w_cand;
    logic [2:0] w_cand_id;
    logic       w_load;
    logic       w_overrun;

    assign w_edge = i_req & ~r_req_q;
    assign w_acc  = r_irq_valid & i_irq_ready;

    always_comb begin
        w_clr = 8'h00;
        if (w_acc) begin
            w_clr[r_irq_id] = 1'b1;
        end
    end

    // A set on the same bit as the clear wins: the bit stays pending as a new event.
    assign w_pend_next = (r_pend & ~w_clr) | w_edge;
    // Candidates use the pending value being loaded, so an accept can hand over
    // to the next id in the same edge and the accepted bit is never re-offered.
    assign w_cand      = w_pend_next & ~i_mask;
    assign w_overrun   = |(w_edge & r_pend & ~w_clr);
    // Output register only reloads when empty or being accepted; otherwise it holds.
    assign w_load      = ~r_irq_valid | w_acc;

    // Ascending scan leaves the highest set index in w_cand_id.
    always_comb begin
        w_cand_id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_cand[i]) begin
                w_cand_id = 3'(i);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_q     <= 8'h00;
            r_pend      <= 8'h00;
            r_irq_valid <= 1'b0;
            r_irq_id    <= 3'd0;
            r_ovf       <= 1'b0;
        end else begin
            r_req_q <= i_req;
            r_pend  <= w_pend_next;
            r_ovf   <= ~i_ovf_clr & (r_ovf | w_overrun);
            if (w_load) begin
                r_irq_valid <= i_en & (|w_cand);
                r_irq_id    <= w_cand_id;
            end
        end
    end

    assign o_irq_valid = r_irq_valid;
    assign o_irq_id    = r_irq_id;
    assign o_pend      = r_pend;
    assign o_ovf       = r_ovf;

endmodule
